// File: rtl/debug_dump_unit_pkg.sv
// debug_dump_unit_pkg: frame constants and state/section encodings for the post-halt dump engine
package debug_dump_unit_pkg;
  localparam logic [7:0] DUMP_HEADER = 8'hA5;
  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_HDR,
    DUMP_ADDR,
    DUMP_CAPT,
    DUMP_WORD,
    DUMP_CSUM,
    DUMP_DONE
  } dump_state_t;
  typedef enum logic [1:0] {
    SEC_PC,
    SEC_REG,
    SEC_MEM
  } dump_sec_t;
endpackage

// File: rtl/debug_dump_unit_serializer.sv
// debug_dump_unit_serializer: MSB-first word-to-byte shifter with running XOR checksum
// Ports: clk/reset (async active-low); clr zeroes the checksum; load/load_data capture a word;
// i_tx_ready sink ready; o_tx_data/o_tx_valid current byte; word_done flags the last byte's
// transfer; csum is the XOR of every byte transferred since clr.
module debug_dump_unit_serializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  word_done,
  output logic [7:0]            csum
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  logic [DATA_WIDTH-1:0] sbuf;
  logic [CW-1:0]         cnt;
  logic                  active;
  logic                  xfer;
  assign xfer       = active && i_tx_ready;
  assign o_tx_valid = active;
  assign o_tx_data  = sbuf[DATA_WIDTH-1 -: 8];
  assign word_done  = xfer && cnt == CW'(BYTES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sbuf   <= '0;
      cnt    <= '0;
      active <= 1'b0;
      csum   <= '0;
    end else begin
      if (clr) csum <= '0;
      else if (xfer) csum <= csum ^ o_tx_data;
      if (load) begin
        sbuf   <= load_data;
        cnt    <= '0;
        active <= 1'b1;
      end else if (xfer) begin
        sbuf   <= sbuf << 8;
        cnt    <= cnt + 1'b1;
        active <= !word_done;
      end
    end
endmodule

// File: rtl/debug_dump_unit.sv
// debug_dump_unit: streams PC, register file and a data-memory window as a framed, checksummed byte stream
// Ports: clk, reset (async active-low); i_start/i_pc dump request and PC; o_reg_addr/i_reg_data
// combinational register read; o_mem_addr/i_mem_data 1-cycle synchronous memory read;
// o_tx_data/o_tx_valid/i_tx_ready byte stream; o_busy while dumping; o_done pulse at end.
module debug_dump_unit
  import debug_dump_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_WORDS  = 32,
  parameter int MEM_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic [REG_ADDR_W-1:0] o_reg_addr,
  input  logic [DATA_WIDTH-1:0] i_reg_data,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int IW = (REG_ADDR_W > MEM_ADDR_W) ? REG_ADDR_W : MEM_ADDR_W;
  dump_state_t           state, state_n;
  dump_sec_t             sec;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] pc_snap;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            ser_data;
  logic [7:0]            csum;
  logic                  ser_valid;
  logic                  word_done;
  logic                  accept;
  logic                  last_reg;
  logic                  last_mem;
  assign accept     = state == DUMP_IDLE && i_start;
  assign last_reg   = idx == IW'(NUM_REGS - 1);
  assign last_mem   = idx == IW'(MEM_WORDS - 1);
  // Addresses come straight from the index register, so they are already stable
  // in ADDR (sync memory sees them at the ADDR edge) and hold through CAPT.
  assign o_reg_addr = sec == SEC_REG ? idx[REG_ADDR_W-1:0] : '0;
  assign o_mem_addr = sec == SEC_MEM ? idx[MEM_ADDR_W-1:0] : '0;
  assign word       = sec == SEC_PC ? pc_snap : sec == SEC_REG ? i_reg_data : i_mem_data;
  assign o_tx_valid = state == DUMP_HDR || state == DUMP_CSUM || ser_valid;
  assign o_tx_data  = state == DUMP_HDR ? DUMP_HEADER : state == DUMP_CSUM ? csum : ser_valid ? ser_data : 8'h00;
  assign o_busy     = state != DUMP_IDLE && state != DUMP_DONE;
  assign o_done     = state == DUMP_DONE;
  debug_dump_unit_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .clr        (accept),
    .load       (state == DUMP_CAPT),
    .load_data  (word),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (ser_data),
    .o_tx_valid (ser_valid),
    .word_done  (word_done),
    .csum       (csum)
  );
  always_comb begin
    state_n = state;
    case (state)
      DUMP_IDLE: state_n = i_start ? DUMP_HDR : DUMP_IDLE;
      DUMP_HDR:  state_n = i_tx_ready ? DUMP_ADDR : DUMP_HDR;
      DUMP_ADDR: state_n = DUMP_CAPT;
      DUMP_CAPT: state_n = DUMP_WORD;
      DUMP_WORD: state_n = !word_done ? DUMP_WORD : (sec == SEC_MEM && last_mem) ? DUMP_CSUM : DUMP_ADDR;
      DUMP_CSUM: state_n = i_tx_ready ? DUMP_DONE : DUMP_CSUM;
      default:   state_n = DUMP_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= DUMP_IDLE;
      sec     <= SEC_PC;
      idx     <= '0;
      pc_snap <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        pc_snap <= i_pc;
        sec     <= SEC_PC;
        idx     <= '0;
      end else if (state == DUMP_WORD && word_done) begin
        if (sec == SEC_PC) begin
          sec <= SEC_REG;
          idx <= '0;
        end else if (sec == SEC_REG && last_reg) begin
          sec <= SEC_MEM;
          idx <= '0;
        end else idx <= idx + 1'b1;
      end
    end
endmodule
